spi_multi_serializer: RTL
=========================

SPI_MULTI_SERIALIZER -- requirements
Module: spi_multi_serializer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning the maximum word length in bits.
REQ-002 SHALL have parameter NUM_CS, default 4, meaning the number of latch-enable (CS) channels.
REQ-003 SHALL have parameter HALF_DIV, default 10, meaning clk cycles per SCLK half-period (legal range 1..65535).
REQ-004 SHALL have ports: clk  in  1  system clock, all logic on rising edge.
REQ-005 SHALL have ports: rst_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have ports: start  in  1  transfer request, sampled on clk.
REQ-007 SHALL have ports: tx_data  in  DATA_WIDTH  word to send.
REQ-008 SHALL have ports: tx_len  in  clog2(DATA_WIDTH+1)  bits to send.
REQ-009 SHALL have ports: cs_sel  in  clog2(NUM_CS) (min 1)  target channel.
REQ-010 SHALL have ports: msb_first  in  1  1 = MSB first, 0 = LSB first.
REQ-011 SHALL have ports: sdo  out  1  serial data.
REQ-012 SHALL have ports: sclk  out  1  SPI clock, idle low.
REQ-013 SHALL have ports: le  out  NUM_CS  per-channel latch-enable, active high.
REQ-014 SHALL have ports: busy  out  1  transfer in progress.
REQ-015 SHALL have ports: done  out  1  single-cycle completion pulse.

Function
REQ-016 SHALL implement FSM states IDLE, SHIFT, LATCH.
REQ-017 In IDLE with start=1, SHALL capture tx_data, tx_len, cs_sel and msb_first into internal registers and enter SHIFT on the next edge; busy=1 from that edge.
REQ-018 Inputs SHALL be ignored while busy=1; start asserted during busy SHALL be dropped, not queued.
REQ-019 Effective length SHALL be tx_len, except that tx_len=0 or tx_len>DATA_WIDTH SHALL be treated as DATA_WIDTH.
REQ-020 The first bit SHALL appear on sdo in the first SHIFT cycle: tx_data[len-1] if msb_first, else tx_data[0].
REQ-021 Each bit SHALL occupy 2*HALF_DIV cycles: sclk low HALF_DIV cycles, then high HALF_DIV cycles.
REQ-022 sdo SHALL change only on the cycle sclk falls, so it is stable across the rising edge.
REQ-023 The half-period counter SHALL reset to 0 on entering SHIFT, so sclk phase is always aligned to start and never free-running.
REQ-024 After the high phase of the last bit, sclk SHALL return low and the FSM SHALL enter LATCH.
REQ-025 In LATCH, le[cs_sel] SHALL be high for exactly HALF_DIV cycles, with all other le bits low and sclk low.
REQ-026 If cs_sel>=NUM_CS, no le bit SHALL assert; the LATCH duration SHALL be unchanged.
REQ-027 At the end of LATCH, the FSM SHALL return to IDLE, deassert busy and pulse done for one cycle.
REQ-028 start on the same cycle done=1 SHALL be accepted (back-to-back).
REQ-029 Total busy duration SHALL be len*2*HALF_DIV + HALF_DIV cycles.
REQ-030 sdo SHALL hold the last-sent bit in IDLE, and 0 after reset.

Reset
REQ-031 rst_n=0 SHALL immediately force sdo=0, sclk=0, le=0, busy=0, done=0, FSM=IDLE and all counters to 0, regardless of state.
REQ-032 Reset mid-transfer SHALL abort it with no le pulse and no done pulse; the first start after rst_n rises SHALL behave as a fresh transfer.

Verification
REQ-033 HALF_DIV=2, tx_data=0xA5, tx_len=8, msb_first=1, cs_sel=1 -> sdo sequence 1,0,1,0,0,1,0,1; 8 sclk pulses of 2-high/2-low; le=0010 for 2 cycles; busy 34 cycles; one done pulse.
REQ-034 Same stimulus with msb_first=0 -> sdo sequence 1,0,1,0,0,1,0,1 (0xA5 is bit-symmetric); repeat with 0x01 -> first bit 1, then seven 0s.
REQ-035 tx_len=0, DATA_WIDTH=32 -> 32 sclk pulses; cs_sel=3 with NUM_CS=3 -> no le activity, done still pulses.
REQ-036 start held high through the transfer plus a second start at the done cycle -> exactly two transfers, with no idle gap beyond one cycle.
REQ-037 rst_n pulsed low at bit 5 -> all outputs 0 asynchronously, no le and no done; a subsequent start completes normally.
REQ-038 HALF_DIV=1, tx_len=1 -> busy 3 cycles, sclk high 1 cycle, le 1 cycle.

Source files
------------

// File: rtl/spi_multi_serializer.sv
// SPI-style serializer: shifts a variable-length word out on sdo/sclk, then pulses
// the latch-enable of the selected channel for one half-period.
module spi_multi_serializer #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_CS     = 4,
   parameter int HALF_DIV   = 10,
   localparam int LW        = $clog2(DATA_WIDTH + 1),
   localparam int CSW       = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] tx_data,
   input  logic [LW-1:0]         tx_len,
   input  logic [CSW-1:0]        cs_sel,
   input  logic                  msb_first,
   output logic                  sdo,
   output logic                  sclk,
   output logic [NUM_CS-1:0]     le,
   output logic                  busy,
   output logic                  done
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_LATCH = 2'd2
   } state_t;

   localparam logic [15:0]   HD_LAST = 16'(HALF_DIV - 1);
   localparam logic [LW-1:0] DW_LEN  = LW'(DATA_WIDTH);

   state_t                r_state;
   logic [15:0]           r_cnt;
   logic                  r_phase_hi;
   logic [LW-1:0]         r_bits_left;
   logic [DATA_WIDTH-1:0] r_shreg;
   logic                  r_msb;
   logic [CSW-1:0]        r_cs;

   logic [LW-1:0]         w_len;
   logic [DATA_WIDTH-1:0] w_aligned;
   logic [NUM_CS-1:0]     w_le_dec;
   logic                  w_next_bit;
   logic [DATA_WIDTH-1:0] w_next_shreg;

   // Out-of-range lengths fall back to a full word; MSB-first data is pre-aligned to the top.
   always_comb begin
      if ((tx_len == {LW{1'b0}}) || (tx_len > DW_LEN)) begin
         w_len = DW_LEN;
      end else begin
         w_len = tx_len;
      end
      w_aligned = tx_data << (DW_LEN - w_len);
   end

   // Channel decode; an out-of-range select leaves every latch-enable low.
   always_comb begin
      w_le_dec = {NUM_CS{1'b0}};
      for (int i = 0; i < NUM_CS; i++) begin
         w_le_dec[i] = (int'(r_cs) == i);
      end
   end

   // Next serial bit and the shift register after it has been consumed.
   always_comb begin
      w_next_bit   = r_msb ? r_shreg[DATA_WIDTH-1] : r_shreg[0];
      w_next_shreg = r_msb ? (r_shreg << 1'b1) : (r_shreg >> 1'b1);
   end

   // Transfer FSM with all outputs registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_cnt       <= 16'd0;
         r_phase_hi  <= 1'b0;
         r_bits_left <= {LW{1'b0}};
         r_shreg     <= {DATA_WIDTH{1'b0}};
         r_msb       <= 1'b0;
         r_cs        <= {CSW{1'b0}};
         sdo         <= 1'b0;
         sclk        <= 1'b0;
         le          <= {NUM_CS{1'b0}};
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  r_msb       <= msb_first;
                  r_cs        <= cs_sel;
                  r_bits_left <= w_len - LW'(1);
                  r_cnt       <= 16'd0;
                  r_phase_hi  <= 1'b0;
                  sclk        <= 1'b0;
                  busy        <= 1'b1;
                  r_state     <= ST_SHIFT;
                  if (msb_first) begin
                     sdo     <= w_aligned[DATA_WIDTH-1];
                     r_shreg <= w_aligned << 1'b1;
                  end else begin
                     sdo     <= tx_data[0];
                     r_shreg <= tx_data >> 1'b1;
                  end
               end
            end
            ST_SHIFT: begin
               if (r_cnt == HD_LAST) begin
                  r_cnt <= 16'd0;
                  if (!r_phase_hi) begin
                     r_phase_hi <= 1'b1;
                     sclk       <= 1'b1;
                  end else begin
                     // Falling edge: either advance to the next bit or go latch.
                     r_phase_hi <= 1'b0;
                     sclk       <= 1'b0;
                     if (r_bits_left == {LW{1'b0}}) begin
                        le      <= w_le_dec;
                        r_state <= ST_LATCH;
                     end else begin
                        r_bits_left <= r_bits_left - LW'(1);
                        sdo         <= w_next_bit;
                        r_shreg     <= w_next_shreg;
                     end
                  end
               end else begin
                  r_cnt <= r_cnt + 16'd1;
               end
            end
            ST_LATCH: begin
               if (r_cnt == HD_LAST) begin
                  r_cnt   <= 16'd0;
                  le      <= {NUM_CS{1'b0}};
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  r_state <= ST_IDLE;
               end else begin
                  r_cnt <= r_cnt + 16'd1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_cnt   <= 16'd0;
               sclk    <= 1'b0;
               le      <= {NUM_CS{1'b0}};
               busy    <= 1'b0;
               done    <= 1'b0;
            end
         endcase
      end
   end

endmodule
